draw_scheduler: RTL and testbench

Frame-level draw sequencer and VGA write arbiter placed between the game control FSM and the per-layer renderers (map, link, optional enemy). On each frame request it enables the renderers in fixed painter's order (map, then link, then enemy), waits for each layer's done, and forwards only the active layer's pixel writes to the VGA adapter through one register stage. A per-layer watchdog guarantees forward progress if a renderer never signals done.

---
 rtl/draw_pkg.sv | 42 ++++
 rtl/layer_watchdog.sv | 29 ++
 rtl/draw_scheduler.sv | 166 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the frame draw sequencer.
// The enemy state exists only when DRAW_SCHED_ENEMY_LAYER_EN is defined.
package draw_pkg;

    localparam int DEF_X_W      = 9;
    localparam int DEF_Y_W      = 8;
    localparam int DEF_COLOUR_W = 3;

    localparam int SCREEN_W      = 320;
    localparam int SCREEN_H      = 240;
    localparam int SCREEN_PIXELS = SCREEN_W * SCREEN_H;

    localparam logic [1:0] LAYER_NONE  = 2'd0;
    localparam logic [1:0] LAYER_MAP   = 2'd1;
    localparam logic [1:0] LAYER_LINK  = 2'd2;
    localparam logic [1:0] LAYER_ENEMY = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP,
        S_LINK,
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
        S_ENEMY,
`endif
        S_DONE
    } state_t;

    function automatic logic [1:0] layer_of(input state_t s);
        logic [1:0] l;
        l = LAYER_NONE;
        case (s)
            S_MAP:   l = LAYER_MAP;
            S_LINK:  l = LAYER_LINK;
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
            S_ENEMY: l = LAYER_ENEMY;
`endif
            default: l = LAYER_NONE;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/layer_watchdog.sv
// Per-layer cycle counter; expire pulses on the last permitted cycle.
module layer_watchdog #(
    parameter int WDOG_CYCLES = 131072
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/draw_scheduler.sv
// Painter's-order layer sequencer and VGA write arbiter.
// Optional enemy layer: define DRAW_SCHED_ENEMY_LAYER_EN.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int COLOUR_W    = DEF_COLOUR_W,
    parameter int WDOG_CYCLES = 131072
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_req,
    input  logic [X_W-1:0]      map_x,
    input  logic [Y_W-1:0]      map_y,
    input  logic [COLOUR_W-1:0] map_colour,
    input  logic                map_write,
    input  logic                map_done,
    input  logic [X_W-1:0]      link_x,
    input  logic [Y_W-1:0]      link_y,
    input  logic [COLOUR_W-1:0] link_colour,
    input  logic                link_write,
    input  logic                link_done,
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
    input  logic [X_W-1:0]      enemy_x,
    input  logic [Y_W-1:0]      enemy_y,
    input  logic [COLOUR_W-1:0] enemy_colour,
    input  logic                enemy_write,
    input  logic                enemy_done,
    output logic                enemy_en,
`endif
    output logic                map_en,
    output logic                link_en,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_write,
    output logic                busy,
    output logic                frame_done,
    output logic                err_timeout
);

    state_t state, state_n;
    logic   pending, pending_n;
    logic [1:0] layer;
    logic   in_layer;
    logic   expire;
    logic   advance;

    logic                src_write;
    logic                src_done;
    logic [X_W-1:0]      src_x;
    logic [Y_W-1:0]      src_y;
    logic [COLOUR_W-1:0] src_colour;

    assign layer    = layer_of(state);
    assign in_layer = (layer != LAYER_NONE);
    assign advance  = in_layer && (src_done || expire);

    // Only the layer owning the current state reaches the VGA stage.
    always_comb begin
        src_write  = 1'b0;
        src_done   = 1'b0;
        src_x      = '0;
        src_y      = '0;
        src_colour = '0;
        case (layer)
            LAYER_MAP: begin
                src_write  = map_write;
                src_done   = map_done;
                src_x      = map_x;
                src_y      = map_y;
                src_colour = map_colour;
            end
            LAYER_LINK: begin
                src_write  = link_write;
                src_done   = link_done;
                src_x      = link_x;
                src_y      = link_y;
                src_colour = link_colour;
            end
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
            LAYER_ENEMY: begin
                src_write  = enemy_write;
                src_done   = enemy_done;
                src_x      = enemy_x;
                src_y      = enemy_y;
                src_colour = enemy_colour;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_n   = state;
        pending_n = pending | (frame_req && (state != S_IDLE));
        unique case (state)
            S_IDLE: if (frame_req) state_n = S_MAP;
            S_MAP:  if (advance) state_n = S_LINK;
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
            S_LINK:  if (advance) state_n = S_ENEMY;
            S_ENEMY: if (advance) state_n = S_DONE;
`else
            S_LINK:  if (advance) state_n = S_DONE;
`endif
            S_DONE: begin
                // A request arriving in DONE is consumed immediately.
                if (pending || frame_req) begin
                    state_n   = S_MAP;
                    pending_n = 1'b0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    layer_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_wdog (
        .clock (clock),
        .reset (reset),
        .clear (state_n != state),
        .enable(in_layer),
        .expire(expire)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pending     <= 1'b0;
            map_en      <= 1'b0;
            link_en     <= 1'b0;
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
            enemy_en    <= 1'b0;
`endif
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            vga_write   <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
        end else begin
            state       <= state_n;
            pending     <= pending_n;
            map_en      <= (state_n == S_MAP);
            link_en     <= (state_n == S_LINK);
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
            enemy_en    <= (state_n == S_ENEMY);
`endif
            busy        <= (state_n != S_IDLE);
            frame_done  <= (state_n == S_DONE);
            err_timeout <= err_timeout | expire;
            vga_write   <= src_write;
            if (src_write) begin
                vga_x      <= src_x;
                vga_y      <= src_y;
                vga_colour <= src_colour;
            end
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: vector table plus multi-cycle sequences.
// Works with or without DRAW_SCHED_ENEMY_LAYER_EN.
module tb_draw_scheduler;

    localparam int WD = 16;

`ifdef DRAW_SCHED_ENEMY_LAYER_EN
    localparam logic [8:0] HX = 9'd200;
    localparam logic [7:0] HY = 8'd100;
    localparam logic [2:0] HC = 3'd6;
    localparam int FD_T = 19;
`else
    localparam logic [8:0] HX = 9'd5;
    localparam logic [7:0] HY = 8'd7;
    localparam logic [2:0] HC = 3'd2;
    localparam int FD_T = 16;
`endif

    logic clock = 1'b0;
    logic reset;
    logic frame_req;
    logic [8:0] map_x, link_x;
    logic [7:0] map_y, link_y;
    logic [2:0] map_colour, link_colour;
    logic map_write, link_write, map_done, link_done;
    logic map_en, link_en, enemy_en_s;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic vga_write, busy, frame_done, err_timeout;
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
    logic [8:0] enemy_x;
    logic [7:0] enemy_y;
    logic [2:0] enemy_colour;
    logic enemy_write, enemy_done;
`else
    assign enemy_en_s = 1'b0;
`endif

    always #5 clock = ~clock;

    draw_scheduler #(
        .X_W(9), .Y_W(8), .COLOUR_W(3), .WDOG_CYCLES(WD)
    ) dut (
        .clock(clock), .reset(reset), .frame_req(frame_req),
        .map_x(map_x), .map_y(map_y), .map_colour(map_colour),
        .map_write(map_write), .map_done(map_done),
        .link_x(link_x), .link_y(link_y), .link_colour(link_colour),
        .link_write(link_write), .link_done(link_done),
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_colour(enemy_colour),
        .enemy_write(enemy_write), .enemy_done(enemy_done),
        .enemy_en(enemy_en_s),
`endif
        .map_en(map_en), .link_en(link_en),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_write(vga_write), .busy(busy), .frame_done(frame_done),
        .err_timeout(err_timeout)
    );

    typedef struct {
        logic       req;
        logic [1:0] ws;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic [2:0] d;
        logic [1:0] el;
        logic       eb, ef, ev;
        logic [8:0] ex;
        logic [7:0] ey;
        logic [2:0] ec;
    } vec_t;

    vec_t vq[$];
    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic req, input logic [1:0] ws,
                         input logic [8:0] x, input logic [7:0] y,
                         input logic [2:0] c, input logic [2:0] d);
        frame_req   = req;
        map_write   = (ws == 2'd1);
        map_x       = (ws == 2'd1) ? x : ~x;
        map_y       = (ws == 2'd1) ? y : ~y;
        map_colour  = (ws == 2'd1) ? c : ~c;
        link_write  = (ws == 2'd2);
        link_x      = (ws == 2'd2) ? x : ~x;
        link_y      = (ws == 2'd2) ? y : ~y;
        link_colour = (ws == 2'd2) ? c : ~c;
        map_done    = d[0];
        link_done   = d[1];
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
        enemy_write  = (ws == 2'd3);
        enemy_x      = (ws == 2'd3) ? x : ~x;
        enemy_y      = (ws == 2'd3) ? y : ~y;
        enemy_colour = (ws == 2'd3) ? c : ~c;
        enemy_done   = d[2];
`endif
    endtask

    task automatic add(input logic req, input logic [1:0] ws,
                       input logic [8:0] x, input logic [7:0] y,
                       input logic [2:0] c, input logic [2:0] d,
                       input logic [1:0] el, input logic eb,
                       input logic ef, input logic ev,
                       input logic [8:0] ex, input logic [7:0] ey,
                       input logic [2:0] ec);
        vec_t v;
        v.req = req; v.ws = ws; v.x = x; v.y = y; v.c = c; v.d = d;
        v.el = el; v.eb = eb; v.ef = ef; v.ev = ev;
        v.ex = ex; v.ey = ey; v.ec = ec;
        vq.push_back(v);
    endtask

    task automatic idle_add(input logic req, input logic [2:0] d,
                            input logic [1:0] el, input logic eb,
                            input logic ef);
        add(req, 2'd0, 9'd0, 8'd0, 3'd0, d, el, eb, ef, 1'b0, HX, HY, HC);
    endtask

    function automatic logic [25:0] observed();
        return {enemy_en_s, link_en, map_en, busy, frame_done, vga_write,
                vga_x, vga_y, vga_colour};
    endfunction

    initial begin
        int mc, lc, enc, fdc, fdt, bad;
        reset = 1'b0;
        drive(1'b0, 2'd0, 9'd0, 8'd0, 3'd0, 3'd0);
        #2;
        check("reset_state", {5'd0, observed(), err_timeout}, 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Single frame with masking and stale-done checks
        add(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 33, 22, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0, 0, 0);
        add(0, 2, 5, 7, 2, 3'b010, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 100, 50, 3, 3'b000, 1, 1, 0, 1, 100, 50, 3);
        add(0, 1, 101, 51, 1, 3'b001, 2, 1, 0, 1, 101, 51, 1);
        add(0, 2, 5, 7, 2, 3'b001, 2, 1, 0, 1, 5, 7, 2);
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
        add(0, 1, 9, 9, 4, 3'b010, 3, 1, 0, 0, 5, 7, 2);
        add(0, 3, 200, 100, 6, 3'b100, 0, 1, 1, 1, 200, 100, 6);
`else
        add(0, 1, 9, 9, 4, 3'b010, 0, 1, 1, 0, 5, 7, 2);
`endif
        idle_add(0, 3'b000, 0, 0, 0);
        // Two requests during MAP give exactly one extra frame
        idle_add(1, 3'b000, 1, 1, 0);
        idle_add(1, 3'b000, 1, 1, 0);
        idle_add(1, 3'b000, 1, 1, 0);
        idle_add(0, 3'b111, 2, 1, 0);
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
        idle_add(0, 3'b111, 3, 1, 0);
`endif
        idle_add(0, 3'b111, 0, 1, 1);
        idle_add(0, 3'b000, 1, 1, 0);
        idle_add(0, 3'b111, 2, 1, 0);
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
        idle_add(0, 3'b111, 3, 1, 0);
`endif
        idle_add(0, 3'b111, 0, 1, 1);
        idle_add(0, 3'b000, 0, 0, 0);
        // Immediate dones, then a request landing in DONE
        idle_add(1, 3'b111, 1, 1, 0);
        idle_add(0, 3'b111, 2, 1, 0);
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
        idle_add(0, 3'b111, 3, 1, 0);
`endif
        idle_add(0, 3'b111, 0, 1, 1);
        idle_add(1, 3'b000, 1, 1, 0);
        idle_add(0, 3'b111, 2, 1, 0);
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
        idle_add(0, 3'b111, 3, 1, 0);
`endif
        idle_add(0, 3'b111, 0, 1, 1);
        idle_add(0, 3'b000, 0, 0, 0);

        foreach (vq[i]) begin
            drive(vq[i].req, vq[i].ws, vq[i].x, vq[i].y, vq[i].c, vq[i].d);
            tick();
            check($sformatf("vec%0d", i), {6'd0, observed()},
                  {6'd0, vq[i].el == 2'd3, vq[i].el == 2'd2,
                   vq[i].el == 2'd1, vq[i].eb, vq[i].ef, vq[i].ev,
                   vq[i].ex, vq[i].ey, vq[i].ec});
        end

        // Layer lengths 10 / 5 / 3
        mc = 0; lc = 0; enc = 0; fdc = 0; fdt = 0;
        drive(1'b1, 2'd0, 9'd0, 8'd0, 3'd0, 3'd0);
        for (int t = 1; t <= 40; t++) begin
            tick();
            frame_req = 1'b0;
            if (map_en) mc++;
            if (link_en) lc++;
            if (enemy_en_s) enc++;
            if (frame_done) begin
                fdc++;
                if (fdt == 0) fdt = t;
            end
            map_done  = map_en && (mc == 10);
            link_done = link_en && (lc == 5);
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
            enemy_done = enemy_en_s && (enc == 3);
`endif
        end
        check("map_len", mc, 10);
        check("link_len", lc, 5);
`ifdef DRAW_SCHED_ENEMY_LAYER_EN
        check("enemy_len", enc, 3);
`endif
        check("fd_count", fdc, 1);
        check("fd_cycle", fdt, FD_T);
        check("busy_after", {31'd0, busy}, 0);
        check("no_timeout", {31'd0, err_timeout}, 0);

        // Watchdog: map_done never arrives
        drive(1'b1, 2'd0, 9'd0, 8'd0, 3'd0, 3'd0);
        tick();
        frame_req = 1'b0;
        mc = 0;
        for (int t = 0; t < 40 && map_en; t++) begin
            mc++;
            tick();
        end
        check("wdog_map_len", mc, WD);
        check("wdog_link_en", {31'd0, link_en}, 1);
        check("wdog_err", {31'd0, err_timeout}, 1);
        drive(1'b0, 2'd0, 9'd0, 8'd0, 3'd0, 3'b110);
        fdc = 0;
        for (int t = 0; t < 10 && fdc == 0; t++) begin
            tick();
            if (frame_done) fdc++;
        end
        check("wdog_frame_end", fdc, 1);
        drive(1'b1, 2'd0, 9'd0, 8'd0, 3'd0, 3'b111);
        fdc = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            frame_req = 1'b0;
            if (frame_done) fdc++;
        end
        check("next_frame_end", fdc, 1);
        check("err_sticky", {31'd0, err_timeout}, 1);

        // Reset in the middle of LINK while link is writing
        drive(1'b1, 2'd0, 9'd0, 8'd0, 3'd0, 3'b000);
        tick();
        drive(1'b0, 2'd0, 9'd0, 8'd0, 3'd0, 3'b001);
        tick();
        drive(1'b0, 2'd2, 9'd5, 8'd7, 3'd1, 3'b000);
        tick();
        check("pre_reset_write", {23'd0, link_en, vga_write, vga_x[6:0]},
              {23'd0, 1'b1, 1'b1, 7'd5});
        reset = 1'b0;
        #1;
        check("mid_reset", {5'd0, observed(), err_timeout}, 32'd0);
        tick();
        reset = 1'b1;
        drive(1'b0, 2'd2, 9'd5, 8'd7, 3'd1, 3'b111);
        bad = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (vga_write || busy || link_en || map_en) bad++;
        end
        check("quiet_after_reset", bad, 0);
        drive(1'b1, 2'd1, 9'd44, 8'd33, 3'd5, 3'b000);
        tick();
        drive(1'b0, 2'd1, 9'd44, 8'd33, 3'd5, 3'b000);
        tick();
        check("restart_write", {6'd0, observed()},
              {6'd0, 3'b001, 1'b1, 1'b0, 1'b1, 9'd44, 8'd33, 3'd5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
